alu: RTL and testbench

- 8-bit ALU for the single-cycle processor datapath.
- The result and the Zero/Parity/Odd status flags are combinational from InputA, InputB, OP and SC_in.
- A single registered carry/shift-carry flag (SC_out) captures the carry/borrow of the current operation each clock. Multi-word add/subtract chains it back through SC_in via the datapath.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_shifter.sv | 48 ++++
 rtl/alu.sv | 93 +++++++++
 tb/tb_alu.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the 8-bit datapath ALU.
package alu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OPW   = 4;

  typedef enum logic [OPW-1:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    RXOR  = 4'd4,
    SHL   = 4'd5,
    SHR   = 4'd6,
    EQ    = 4'd7,
    LT    = 4'd8,
    XOR   = 4'd9,
    ADC   = 4'd10,
    SBB   = 4'd11,
    NOT   = 4'd12,
    ROL   = 4'd13,
    ROR   = 4'd14,
    PASSB = 4'd15
  } op_t;

endpackage

// File: rtl/alu_shifter.sv
// Logical shifts and rotates for the ALU, with the last shifted-out bit as carry.
module alu_shifter #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  alu_pkg::op_t     op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry
);
  import alu_pkg::*;

  localparam int unsigned AW = $clog2(WIDTH);

  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [2*WIDTH-1:0] rol_ext;
  logic [2*WIDTH-1:0] ror_ext;
  logic [AW-1:0]      rot;

  // One guard bit beyond the data catches the last bit shifted out; any
  // amount past WIDTH pushes everything (guard included) out to zero.
  assign shl_ext = {1'b0, a} << b;
  assign shr_ext = {a, 1'b0} >> b;

  assign rot     = b[AW-1:0];
  assign rol_ext = {a, a} << rot;
  assign ror_ext = {a, a} >> rot;

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (op)
      SHL: begin
        out   = shl_ext[WIDTH-1:0];
        carry = shl_ext[WIDTH];
      end
      SHR: begin
        out   = shr_ext[WIDTH:1];
        carry = shr_ext[0];
      end
      ROL:     out = rol_ext[2*WIDTH-1:WIDTH];
      ROR:     out = ror_ext[WIDTH-1:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 8-bit combinational ALU with registered carry/borrow flag for multi-word chains.
module alu #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             SC_in,
  input  logic [OPW-1:0]   OP,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Parity,
  output logic             Odd,
  output logic             SC_out
);
  import alu_pkg::*;

  op_t              op;
  logic             add_cin;
  logic             sub_bin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_out;
  logic             sh_carry;
  logic [WIDTH-1:0] res;
  logic             sc_d;
  logic             sc_q;

  assign op = op_t'(OP);

  // SC_in only participates in the chained forms.
  assign add_cin = (op == ADC) & SC_in;
  assign sub_bin = (op == SBB) & SC_in;

  assign sum  = {1'b0, InputA} + {1'b0, InputB} + {{WIDTH{1'b0}}, add_cin};
  // Bit WIDTH of the wrapped difference is the borrow.
  assign diff = {1'b0, InputA} - {1'b0, InputB} - {{WIDTH{1'b0}}, sub_bin};

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .op    (op),
    .a     (InputA),
    .b     (InputB),
    .out   (sh_out),
    .carry (sh_carry)
  );

  always_comb begin
    res  = '0;
    sc_d = 1'b0;
    unique case (op)
      ADD, ADC: begin
        res  = sum[WIDTH-1:0];
        sc_d = sum[WIDTH];
      end
      SUB, SBB: begin
        res  = diff[WIDTH-1:0];
        sc_d = diff[WIDTH];
      end
      AND:   res = InputA & InputB;
      OR:    res = InputA | InputB;
      RXOR:  res = {{(WIDTH-1){1'b0}}, ^InputB};
      SHL, SHR, ROL, ROR: begin
        res  = sh_out;
        sc_d = sh_carry;
      end
      EQ:    res = {{(WIDTH-1){1'b0}}, InputA == InputB};
      LT:    res = {{(WIDTH-1){1'b0}}, InputA < InputB};
      XOR:   res = InputA ^ InputB;
      NOT:   res = ~InputA;
      PASSB: res = InputB;
    endcase
  end

  assign Out    = res;
  assign Zero   = (res == '0);
  assign Parity = ^res;
  assign Odd    = res[0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sc_q <= 1'b0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign SC_out = sc_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed tables plus a randomised run against a bench model.
module tb_alu;

  typedef struct {
    logic [7:0] out;
    logic       carry;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] out;
    logic       carry;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       SC_in;
  logic [3:0] OP;
  logic [7:0] Out;
  logic       Zero;
  logic       Parity;
  logic       Odd;
  logic       SC_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .InputA (InputA),
    .InputB (InputB),
    .SC_in  (SC_in),
    .OP     (OP),
    .Out    (Out),
    .Zero   (Zero),
    .Parity (Parity),
    .Odd    (Odd),
    .SC_out (SC_out)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    @(negedge Clk);
    OP     = op;
    InputA = a;
    InputB = b;
    SC_in  = cin;
  endtask

  // Independent reference: shifts/rotates step one bit at a time.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    exp_t        m;
    int unsigned s;
    logic [7:0]  r;
    logic [2:0]  rot;
    logic        c;
    r   = a;
    c   = 1'b0;
    rot = b[2:0];
    case (op)
      4'd0:  begin s = a + b; r = s[7:0]; c = s[8]; end
      4'd1:  begin r = a - b; c = (a < b); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = {7'd0, ^b};
      4'd5:  for (int i = 0; i < int'(b) && i < 9; i++) begin c = r[7]; r = r << 1; end
      4'd6:  for (int i = 0; i < int'(b) && i < 9; i++) begin c = r[0]; r = r >> 1; end
      4'd7:  r = {7'd0, a == b};
      4'd8:  r = {7'd0, a < b};
      4'd9:  r = a ^ b;
      4'd10: begin s = a + b + cin; r = s[7:0]; c = s[8]; end
      4'd11: begin r = a - b - cin; c = (int'(a) < int'(b) + int'(cin)); end
      4'd12: r = ~a;
      4'd13: for (int i = 0; i < int'(rot); i++) r = {r[6:0], r[7]};
      4'd14: for (int i = 0; i < int'(rot); i++) r = {r[0], r[7:1]};
      default: r = b;
    endcase
    m.out   = r;
    m.carry = c;
    return m;
  endfunction

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1;
    drive(4'd0, 8'd4, 8'd1, 1'b0);
    sb.push_back('{out: 8'd5, carry: 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
      errors++;
      $display("FAIL reset_comb got out=%h z=%b p=%b o=%b exp out=%h", Out, Zero, Parity, Odd,
               e.out);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (SC_out !== e.carry) begin
      errors++;
      $display("FAIL reset_sc got %b exp %b", SC_out, e.carry);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    vec_t v[9] = '{
      '{4'd0, 8'd4, 8'd1, 1'b0, 8'd5, 1'b0},
      '{4'd1, 8'd4, 8'd1, 1'b0, 8'd3, 1'b0},
      '{4'd2, 8'd4, 8'd1, 1'b0, 8'd0, 1'b0},
      '{4'd3, 8'd4, 8'd1, 1'b0, 8'd5, 1'b0},
      '{4'd4, 8'd4, 8'd1, 1'b0, 8'd1, 1'b0},
      '{4'd5, 8'd4, 8'd1, 1'b0, 8'd8, 1'b0},
      '{4'd6, 8'd4, 8'd1, 1'b0, 8'd2, 1'b0},
      '{4'd7, 8'd4, 8'd1, 1'b0, 8'd0, 1'b0},
      '{4'd8, 8'd4, 8'd1, 1'b0, 8'd0, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].cin);
      sb.push_back('{out: v[i].out, carry: v[i].carry});
      #1;
      e = sb.pop_front();
      checks++;
      if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
        errors++;
        $display("FAIL basic[%0d] op=%0d got out=%h z=%b p=%b o=%b exp out=%h", i, v[i].op,
                 Out, Zero, Parity, Odd, e.out);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (SC_out !== e.carry) begin
        errors++;
        $display("FAIL basic_sc[%0d] got %b exp %b", i, SC_out, e.carry);
      end
    end
  endtask

  task automatic test_carry_chain();
    exp_t e;
    vec_t v[4] = '{
      '{4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
      '{4'd10, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0},
      '{4'd1,  8'h01, 8'h02, 1'b0, 8'hFF, 1'b1},
      '{4'd11, 8'h05, 8'h02, 1'b1, 8'h02, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].cin);
      sb.push_back('{out: v[i].out, carry: v[i].carry});
      #1;
      e = sb.pop_front();
      checks++;
      if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
        errors++;
        $display("FAIL chain[%0d] op=%0d got out=%h z=%b p=%b o=%b exp out=%h", i, v[i].op,
                 Out, Zero, Parity, Odd, e.out);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (SC_out !== e.carry) begin
        errors++;
        $display("FAIL chain_sc[%0d] got %b exp %b", i, SC_out, e.carry);
      end
    end
  endtask

  task automatic test_shifts();
    exp_t e;
    vec_t v[9] = '{
      '{4'd5,  8'h81, 8'd1, 1'b0, 8'h02, 1'b1},
      '{4'd6,  8'h81, 8'd8, 1'b0, 8'h00, 1'b1},
      '{4'd6,  8'h81, 8'd9, 1'b0, 8'h00, 1'b0},
      '{4'd13, 8'h81, 8'd1, 1'b0, 8'h03, 1'b0},
      '{4'd5,  8'h81, 8'd8, 1'b0, 8'h00, 1'b1},
      '{4'd5,  8'h81, 8'd0, 1'b0, 8'h81, 1'b0},
      '{4'd6,  8'h81, 8'd0, 1'b0, 8'h81, 1'b0},
      '{4'd14, 8'h81, 8'd1, 1'b0, 8'hC0, 1'b0},
      '{4'd13, 8'h81, 8'd9, 1'b0, 8'h03, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].cin);
      sb.push_back('{out: v[i].out, carry: v[i].carry});
      #1;
      e = sb.pop_front();
      checks++;
      if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
        errors++;
        $display("FAIL shift[%0d] op=%0d b=%0d got out=%h z=%b p=%b o=%b exp out=%h", i,
                 v[i].op, v[i].b, Out, Zero, Parity, Odd, e.out);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (SC_out !== e.carry) begin
        errors++;
        $display("FAIL shift_sc[%0d] got %b exp %b", i, SC_out, e.carry);
      end
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    drive(4'd0, 8'hFF, 8'h01, 1'b0);
    @(posedge Clk);
    #1;
    checks++;
    if (SC_out !== 1'b1) begin
      errors++;
      $display("FAIL rstpri_setup got %b exp 1", SC_out);
    end
    drive(4'd0, 8'hFF, 8'h02, 1'b0);
    Reset = 1'b1;
    sb.push_back('{out: 8'h01, carry: 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
      errors++;
      $display("FAIL rstpri_comb got out=%h z=%b p=%b o=%b exp out=%h", Out, Zero, Parity, Odd,
               e.out);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (SC_out !== e.carry) begin
      errors++;
      $display("FAIL rstpri_sc got %b exp %b", SC_out, e.carry);
    end
    checks++;
    if (Out !== 8'h01) begin
      errors++;
      $display("FAIL rstpri_out_after got %h exp 01", Out);
    end
    Reset = 1'b0;
  endtask

  task automatic test_misc();
    exp_t e;
    vec_t v[6] = '{
      '{4'd7,  8'h3C, 8'h3C, 1'b0, 8'h01, 1'b0},
      '{4'd8,  8'd3,  8'd200, 1'b0, 8'h01, 1'b0},
      '{4'd12, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0},
      '{4'd15, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b0},
      '{4'd9,  8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0},
      '{4'd4,  8'hFF, 8'h03, 1'b0, 8'h00, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].cin);
      sb.push_back('{out: v[i].out, carry: v[i].carry});
      #1;
      e = sb.pop_front();
      checks++;
      if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
        errors++;
        $display("FAIL misc[%0d] op=%0d got out=%h z=%b p=%b o=%b exp out=%h", i, v[i].op,
                 Out, Zero, Parity, Odd, e.out);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (SC_out !== e.carry) begin
        errors++;
        $display("FAIL misc_sc[%0d] got %b exp %b", i, SC_out, e.carry);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    for (int i = 0; i < 400; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      cin = 1'($urandom);
      drive(op, a, b, cin);
      sb.push_back(model(op, a, b, cin));
      #1;
      e = sb.pop_front();
      checks++;
      if ({Out, Zero, Parity, Odd} !== {e.out, e.out == 8'd0, ^e.out, e.out[0]}) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h cin=%b got out=%h z=%b p=%b o=%b exp out=%h",
                 i, op, a, b, cin, Out, Zero, Parity, Odd, e.out);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (SC_out !== e.carry) begin
        errors++;
        $display("FAIL rand_sc[%0d] op=%0d a=%h b=%h cin=%b got %b exp %b", i, op, a, b, cin,
                 SC_out, e.carry);
      end
    end
  endtask

  initial begin
    Reset  = 1'b1;
    OP     = 4'd0;
    InputA = 8'd0;
    InputB = 8'd0;
    SC_in  = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_shifts();
    test_reset_priority();
    test_misc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
